// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the multiplier round-robin scheduler.
// Holds the tag pipe entry type and the ID width helper.
package mult_sched_pkg;

  // Upper bound on ID width carried by a tag entry (up to 256 requesters).
  localparam int TAG_ID_W = 8;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } mult_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the pointer.
// Pointer moves to the granted index only when advance is high.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic            found;

  // Search above the pointer first, then wrap to the low indices.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && (i > int'(ptr_q)) && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && (i <= int'(ptr_q)) && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = ID_W'(i);
      end
    end
  end

  // Pointer follows the last accepted grant.
  always_comb begin
    ptr_d = advance ? idx : ptr_q;
  end

  // Reset pointer to the last index so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/multiplier_rr_scheduler.sv
// Shares one fixed-latency multiplier among NUM_REQ requesters.
// A tag pipe tracks each issued pair and routes its product home.
module multiplier_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MULT_LATENCY = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [2*DATA_WIDTH-1:0]             rsp_data,
  output logic [DATA_WIDTH-1:0]               mul_in1,
  output logic [DATA_WIDTH-1:0]               mul_in2,
  output logic                                mul_in_valid,
  input  logic [2*DATA_WIDTH-1:0]             mul_out,
  input  logic                                mul_out_valid,
  output logic                                busy,
  output logic                                proto_err
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int DEPTH = MULT_LATENCY + 1;

  logic [NUM_REQ-1:0]    arb_req;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  hs;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;

  logic [DATA_WIDTH-1:0]   mul_in1_q, mul_in1_d;
  logic [DATA_WIDTH-1:0]   mul_in2_q, mul_in2_d;
  logic                    mul_in_valid_q, mul_in_valid_d;
  mult_tag_t [DEPTH-1:0]   tag_q, tag_d;
  mult_tag_t               tail;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    proto_err_q, proto_err_d;
  logic                    any_vld;

  assign arb_req = req_valid & {NUM_REQ{enable}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (reset),
    .req     (arb_req),
    .advance (hs),
    .gnt     (gnt),
    .idx     (gnt_idx)
  );

  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);
  assign tail      = tag_q[DEPTH-1];

  // Pick the granted requester's operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i];
        sel_b = req_b[i];
      end
    end
  end

  // Register operands on handshake; hold them otherwise.
  always_comb begin
    mul_in_valid_d = hs;
    mul_in1_d      = hs ? sel_a : mul_in1_q;
    mul_in2_d      = hs ? sel_b : mul_in2_q;
  end

  // Tag pipe shifts every cycle; head aligns with mul_in_valid.
  always_comb begin
    tag_d        = '0;
    tag_d[0].vld = hs;
    tag_d[0].id  = TAG_ID_W'(gnt_idx);
    for (int k = 1; k < DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  // Route matched products home; flag valid/tag disagreement.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tail.vld && mul_out_valid) begin
      rsp_data_d = mul_out;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tail.id == TAG_ID_W'(i)) begin
          rsp_valid_d[i] = 1'b1;
        end
      end
    end
    proto_err_d = proto_err_q | (mul_out_valid != tail.vld);
  end

  // Any tag still travelling keeps the block busy.
  always_comb begin
    any_vld = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      any_vld = any_vld | tag_q[k].vld;
    end
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_in1_q      <= '0;
      mul_in2_q      <= '0;
      mul_in_valid_q <= 1'b0;
      tag_q          <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      mul_in1_q      <= mul_in1_d;
      mul_in2_q      <= mul_in2_d;
      mul_in_valid_q <= mul_in_valid_d;
      tag_q          <= tag_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign mul_in1      = mul_in1_q;
  assign mul_in2      = mul_in2_q;
  assign mul_in_valid = mul_in_valid_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign proto_err    = proto_err_q;
  assign busy         = mul_in_valid_q | any_vld | (|rsp_valid_q);

endmodule

// File: tb/tb_multiplier_rr_scheduler.sv
// Directed bench for multiplier_rr_scheduler with a 3-cycle multiplier model.
// Stray/missing multiplier valids are injected through the model.
module tb_multiplier_rr_scheduler;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][31:0] req_a;
  logic [3:0][31:0] req_b;
  logic [3:0]       rsp_valid;
  logic [63:0]      rsp_data;
  logic [31:0]      mul_in1;
  logic [31:0]      mul_in2;
  logic             mul_in_valid;
  logic [63:0]      mul_out;
  logic             mul_out_valid;
  logic             busy;
  logic             proto_err;

  logic             inject;
  logic             suppress;
  logic [2:0]       pv;
  logic [2:0][63:0] pd;

  int n_cmp;
  int n_err;

  multiplier_rr_scheduler #(
    .NUM_REQ      (4),
    .DATA_WIDTH   (32),
    .MULT_LATENCY (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .mul_in1       (mul_in1),
    .mul_in2       (mul_in2),
    .mul_in_valid  (mul_in_valid),
    .mul_out       (mul_out),
    .mul_out_valid (mul_out_valid),
    .busy          (busy),
    .proto_err     (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three-stage multiplier model sharing the scheduler reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      pd <= '0;
    end else begin
      pv <= {pv[1:0], mul_in_valid};
      pd <= {pd[1:0], {32'd0, mul_in1} * {32'd0, mul_in2}};
    end
  end

  assign mul_out_valid = (pv[2] & ~suppress) | inject;
  assign mul_out       = pd[2];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    enable    = 1'b1;
    req_valid = '0;
    inject    = 1'b0;
    suppress  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] prod [4];
    logic [3:0]  vp   [5];
    int          g    [5];
    logic [3:0]  oh;

    n_cmp  = 0;
    n_err  = 0;
    req_a  = '0;
    req_b  = '0;
    reset  = 1'b0;
    enable = 1'b1;
    req_valid = '0;
    inject    = 1'b0;
    suppress  = 1'b0;

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_mul_in_valid", 64'(mul_in_valid), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mul_in1", 64'(mul_in1), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);

    // 1: single request, 7*6.
    do_reset();
    req_a[0]  = 32'd7;
    req_b[0]  = 32'd6;
    req_valid = 4'b0001;
    #1;
    check("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    check("t1_in_valid", 64'(mul_in_valid), 64'd1);
    check("t1_in1", 64'(mul_in1), 64'd7);
    check("t1_in2", 64'(mul_in2), 64'd6);
    check("t1_busy", 64'(busy), 64'd1);
    for (int k = 2; k < 5; k++) begin
      tick();
      check("t1_no_rsp", 64'(rsp_valid), 64'd0);
      check("t1_in_valid_low", 64'(mul_in_valid), 64'd0);
    end
    check("t1_in1_hold", 64'(mul_in1), 64'd7);
    tick();
    check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t1_rsp_data", rsp_data, 64'd42);
    check("t1_busy_rsp", 64'(busy), 64'd1);
    tick();
    check("t1_rsp_pulse", 64'(rsp_valid), 64'd0);
    check("t1_busy_idle", 64'(busy), 64'd0);
    check("t1_proto_err", 64'(proto_err), 64'd0);

    // 2: all four valid, back-to-back round-robin.
    do_reset();
    req_a[0] = 32'd10;         req_b[0] = 32'd3;
    req_a[1] = 32'd11;         req_b[1] = 32'd5;
    req_a[2] = 32'd12;         req_b[2] = 32'd7;
    req_a[3] = 32'hFFFF_FFFF;  req_b[3] = 32'hFFFF_FFFF;
    prod[0] = 64'd30;
    prod[1] = 64'd55;
    prod[2] = 64'd84;
    prod[3] = 64'hFFFF_FFFE_0000_0001;
    for (int k = 0; k < 14; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) begin
        oh = 4'(1 << (k % 4));
        check("t2_grant", 64'(req_ready), 64'(oh));
      end
      if (k >= 1 && k <= 8) begin
        check("t2_in_valid", 64'(mul_in_valid), 64'd1);
      end
      if (k >= 5 && k < 13) begin
        oh = 4'(1 << ((k - 5) % 4));
        check("t2_rsp_valid", 64'(rsp_valid), 64'(oh));
        check("t2_rsp_data", rsp_data, prod[(k - 5) % 4]);
      end else begin
        check("t2_rsp_idle", 64'(rsp_valid), 64'd0);
      end
      if (k == 13) begin
        check("t2_busy_idle", 64'(busy), 64'd0);
      end
      tick();
    end

    // 3: fairness, req2 held while req0 pulses.
    do_reset();
    req_a[0] = 32'd3;  req_b[0] = 32'd4;
    req_a[2] = 32'd5;  req_b[2] = 32'd5;
    prod[0] = 64'd12;
    prod[2] = 64'd25;
    vp[0] = 4'b0101;  g[0] = 0;
    vp[1] = 4'b0101;  g[1] = 2;
    vp[2] = 4'b0101;  g[2] = 0;
    vp[3] = 4'b0100;  g[3] = 2;
    vp[4] = 4'b0101;  g[4] = 0;
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 5) ? vp[k] : 4'b0000;
      #1;
      if (k < 5) begin
        oh = 4'(1 << g[k]);
        check("t3_grant", 64'(req_ready), 64'(oh));
      end else begin
        oh = 4'(1 << g[k - 5]);
        check("t3_rsp_valid", 64'(rsp_valid), 64'(oh));
        check("t3_rsp_data", rsp_data, prod[g[k - 5]]);
      end
      tick();
    end

    // 4: enable drops with three operations in flight.
    do_reset();
    req_a[0] = 32'd2;  req_b[0] = 32'd9;
    req_a[1] = 32'd3;  req_b[1] = 32'd11;
    req_a[2] = 32'd4;  req_b[2] = 32'd25;
    prod[0] = 64'd18;
    prod[1] = 64'd33;
    prod[2] = 64'd100;
    for (int k = 0; k < 10; k++) begin
      enable    = (k < 3);
      req_valid = 4'b0111;
      #1;
      if (k < 3) begin
        oh = 4'(1 << k);
        check("t4_grant", 64'(req_ready), 64'(oh));
      end else begin
        check("t4_no_grant", 64'(req_ready), 64'd0);
      end
      if (k >= 5 && k <= 7) begin
        oh = 4'(1 << (k - 5));
        check("t4_rsp_valid", 64'(rsp_valid), 64'(oh));
        check("t4_rsp_data", rsp_data, prod[k - 5]);
      end
      if (k == 7) check("t4_busy_last", 64'(busy), 64'd1);
      if (k == 8) check("t4_busy_drop", 64'(busy), 64'd0);
      tick();
    end
    req_valid = '0;
    enable    = 1'b1;

    // 5a: stray multiplier valid.
    do_reset();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    #1;
    check("t5_stray_err", 64'(proto_err), 64'd1);
    check("t5_stray_rsp", 64'(rsp_valid), 64'd0);
    repeat (3) tick();
    check("t5_stray_sticky", 64'(proto_err), 64'd1);
    check("t5_stray_busy", 64'(busy), 64'd0);

    // 5b: missing multiplier valid drops the response.
    do_reset();
    check("t5_err_cleared", 64'(proto_err), 64'd0);
    req_a[1]  = 32'd5;
    req_b[1]  = 32'd5;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    repeat (3) tick();
    suppress = 1'b1;
    #1;
    check("t5_miss_pre", 64'(proto_err), 64'd0);
    tick();
    suppress = 1'b0;
    #1;
    check("t5_miss_err", 64'(proto_err), 64'd1);
    check("t5_miss_rsp", 64'(rsp_valid), 64'd0);
    tick();
    check("t5_miss_rsp2", 64'(rsp_valid), 64'd0);

    // 6: asynchronous reset with two in flight.
    do_reset();
    req_a[0] = 32'd9;  req_b[0] = 32'd9;
    req_a[1] = 32'd2;  req_b[1] = 32'd2;
    req_valid = 4'b0011;
    #1;
    check("t6_grant0", 64'(req_ready), 64'h1);
    tick();
    #1;
    check("t6_grant1", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b0000;
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_in_valid", 64'(mul_in_valid), 64'd0);
    check("t6_async_busy", 64'(busy), 64'd0);
    check("t6_async_in1", 64'(mul_in1), 64'd0);
    check("t6_async_rsp", 64'(rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("t6_no_stale_rsp", 64'(rsp_valid), 64'd0);
    end
    req_valid = 4'b0101;
    #1;
    check("t6_ptr_restart", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    check("t6_in1", 64'(mul_in1), 64'd9);
    repeat (4) tick();
    check("t6_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t6_rsp_data", rsp_data, 64'd81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
